pl_pc_ctrl: RTL and testbench
=============================

Name: pl_pc_ctrl

Overview:
Next-PC scheduler and write-enable controller for the fetch-stage PC register. Every cycle it arbitrates between sequential fetch, ID-stage JAL, EX-stage taken branch and trap redirects. It produces the register's next value (npc) and write enable (wpcir), plus IF/ID flush strobes. It holds redirects that arrive while instruction memory is not ready, supports a halt/resume state, and counts stall cycles.

Parameters:
RESET_VEC, 32'h0000_0000, value driven on npc while in reset; matches the PC register's reset value.
STALL_CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
clrn  in  1  synchronous active-low reset
pc  in  32  current PC (PC register output)
imem_ready  in  1  instruction memory accepts a fetch this cycle
stall_lu  in  1  load-use hazard from ID; hold PC
jal_valid  in  1  JAL decoded in ID
jal_target  in  32  JAL target
br_taken  in  1  taken branch or JALR resolved in EX
br_target  in  32  branch/JALR target
trap_req  in  1  exception or interrupt redirect
trap_vec  in  32  trap handler address
halt_req  in  1  request halt (ebreak/debug)
resume  in  1  leave HALT
npc  out  32  next PC to the PC register
wpcir  out  1  PC write enable
flush_if  out  1  squash IF/ID register contents
flush_id  out  1  squash ID/EX register contents
halted  out  1  controller is in HALT
stall_cycles  out  STALL_CNT_W  saturating count of non-halted cycles with wpcir=0

Behaviour:
- Reset is synchronous and active-low: clk, clrn. While clrn=0 at a clk edge: state<=RUN, pend_valid<=0, pend_is_trap<=0, stall_cycles<=0. While clrn=0, outputs are npc=RESET_VEC, wpcir=0, flush_if=0, flush_id=0, halted=0.
- npc, wpcir and the flush outputs are combinational from state and inputs (zero latency). The PC updates at the next edge when wpcir=1.
- Target alignment: every selected target has bits [1:0] forced to 0. The sequential increment is pc+4 mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- The FSM has three states: RUN, PEND, HALT.
- RUN, with priority from highest to lowest:
  - trap_req: npc=trap_vec, flush_if=flush_id=1.
  - br_taken: npc=br_target, flush_if=flush_id=1.
  - halt_req: wpcir=0, next state HALT.
  - stall_lu: wpcir=0, npc=pc. A JAL waiting behind stall_lu is not taken.
  - jal_valid: npc=jal_target, flush_if=1.
  - Otherwise: npc=pc+4.
  - wpcir=1 for every redirect and sequential case above when imem_ready=1.
- RUN with imem_ready=0:
  - wpcir=0.
  - A trap or branch still asserts its flushes this cycle, latches pend_pc and pend_is_trap (1 for trap), and goes to PEND.
  - A JAL latches pend_pc with flush_if and goes to PEND.
  - Non-redirect cycles stay in RUN.
- PEND:
  - wpcir=0 until imem_ready=1. Then npc=pend_pc, wpcir=1, pend cleared, state RUN.
  - A new trap_req overwrites pend_pc and sets pend_is_trap, with flushes.
  - A new br_taken overwrites only if pend_is_trap=0.
  - jal_valid, stall_lu and halt_req are ignored in PEND. Halt is re-evaluated in RUN.
  - If trap_req and imem_ready coincide, the new trap target is used directly.
- HALT:
  - halted=1, wpcir=0, no flushes.
  - resume goes to RUN next cycle. There is no PC write on the resume cycle.
  - trap_req wakes: it behaves as the RUN trap case, entering PEND if imem_ready=0.
  - The counter does not increment in HALT.
- stall_cycles increments on each cycle in RUN/PEND with wpcir=0, and saturates at all-ones.
- A reset mid-PEND or mid-HALT discards the pending target; no flush is emitted.

Decomposition:
- Shared package pl_pkg: state enum (RUN, PEND, HALT), PC_INC=32'd4, RESET_VEC default, alignment mask 32'hFFFF_FFFC.
- Sub-module pl_pc_sel: purely combinational priority mux. It takes the redirect valids/targets and pc, and returns the selected target, redirect class and flush pair. The FSM, pending register and counter stay in pl_pc_ctrl.

Test Plan:
1. Reset, then 3 cycles with imem_ready=1 and no events -> npc goes 0x0, then 0x4, 0x8, 0xC; wpcir=1; flushes 0.
2. pc=0x40, stall_lu=1 and jal_valid=1 (target 0x80) for 2 cycles, then stall drops -> wpcir=0 and npc=0x40 for 2 cycles, stall_cycles=2; next cycle npc=0x80, flush_if=1, flush_id=0.
3. br_taken (0x200) with trap_req (vec 0x100) in the same cycle, and separately br_taken with stall_lu -> trap wins: npc=0x100, both flushes; branch beats stall: npc=0x200, wpcir=1.
4. br_taken (0x300) with imem_ready=0; next cycle trap_req (0x100); 2 cycles later imem_ready=1 -> flushes on both event cycles, wpcir=0 throughout; on the ready cycle npc=0x100, state RUN. A later branch cannot overwrite a pending trap.
5. halt_req at pc=0x50, resume after 4 cycles -> halted=1 and wpcir=0 for 4 cycles, stall_cycles unchanged; after resume npc=0x54 on the following cycle.
6. pc=32'hFFFF_FFFC sequential -> npc=0x0. jal_target=0x103 -> npc=0x100. clrn=0 asserted while in PEND -> pend cleared, npc=RESET_VEC, stall_cycles=0.

Source files
------------

// File: rtl/pl_pc_ctrl_pkg.sv
// Shared types and constants for the fetch-stage next-PC controller.
package pl_pkg;

    typedef enum logic [1:0] {
        RUN,
        PEND,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_BR,
        SEL_HALT,
        SEL_STALL,
        SEL_JAL,
        SEL_SEQ
    } sel_t;

    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pl_pc_sel.sv
// Combinational priority mux for the next-PC source: trap > branch > halt > stall > jal > sequential.
module pl_pc_sel
    import pl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        trap_req,
    input  logic [31:0] trap_vec,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    input  logic        stall_lu,
    input  logic        jal_valid,
    input  logic [31:0] jal_target,
    output logic [31:0] sel_target,
    output sel_t        sel_class,
    output logic        sel_flush_if,
    output logic        sel_flush_id
);

    always_comb begin
        sel_target   = pc + PC_INC;
        sel_class    = SEL_SEQ;
        sel_flush_if = 1'b0;
        sel_flush_id = 1'b0;
        if (trap_req) begin
            sel_target   = align_pc(trap_vec);
            sel_class    = SEL_TRAP;
            sel_flush_if = 1'b1;
            sel_flush_id = 1'b1;
        end else if (br_taken) begin
            sel_target   = align_pc(br_target);
            sel_class    = SEL_BR;
            sel_flush_if = 1'b1;
            sel_flush_id = 1'b1;
        end else if (halt_req) begin
            sel_target = pc;
            sel_class  = SEL_HALT;
        end else if (stall_lu) begin
            // A JAL sitting behind a load-use stall is re-decoded once the stall clears.
            sel_target = pc;
            sel_class  = SEL_STALL;
        end else if (jal_valid) begin
            sel_target   = align_pc(jal_target);
            sel_class    = SEL_JAL;
            sel_flush_if = 1'b1;
        end
    end

endmodule

// File: rtl/pl_pc_ctrl.sv
// Next-PC scheduler: RUN/PEND/HALT FSM, pending-redirect register and saturating stall counter.
module pl_pc_ctrl
    import pl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = RESET_VEC_DEF,
    parameter int          STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic [31:0]            pc,
    input  logic                   imem_ready,
    input  logic                   stall_lu,
    input  logic                   jal_valid,
    input  logic [31:0]            jal_target,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    input  logic                   trap_req,
    input  logic [31:0]            trap_vec,
    input  logic                   halt_req,
    input  logic                   resume,
    output logic [31:0]            npc,
    output logic                   wpcir,
    output logic                   flush_if,
    output logic                   flush_id,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_t      state, state_nx;
    logic        pend_valid, pend_valid_nx;
    logic        pend_is_trap, pend_is_trap_nx;
    logic [31:0] pend_pc, pend_pc_nx;

    logic [31:0] sel_target;
    sel_t        sel_class;
    logic        sel_flush_if, sel_flush_id;

    pl_pc_sel u_sel (
        .pc           (pc),
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .halt_req     (halt_req),
        .stall_lu     (stall_lu),
        .jal_valid    (jal_valid),
        .jal_target   (jal_target),
        .sel_target   (sel_target),
        .sel_class    (sel_class),
        .sel_flush_if (sel_flush_if),
        .sel_flush_id (sel_flush_id)
    );

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state        <= RUN;
            pend_valid   <= 1'b0;
            pend_is_trap <= 1'b0;
            pend_pc      <= RESET_VEC;
        end else begin
            state        <= state_nx;
            pend_valid   <= pend_valid_nx;
            pend_is_trap <= pend_is_trap_nx;
            pend_pc      <= pend_pc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            stall_cycles <= '0;
        end else if (state != HALT && !wpcir && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nx        = state;
        pend_valid_nx   = pend_valid;
        pend_is_trap_nx = pend_is_trap;
        pend_pc_nx      = pend_pc;
        npc             = pc;
        wpcir           = 1'b0;
        flush_if        = 1'b0;
        flush_id        = 1'b0;
        halted          = 1'b0;
        if (!clrn) begin
            npc = RESET_VEC;
        end else begin
            case (state)
                RUN: begin
                    npc      = sel_target;
                    flush_if = sel_flush_if;
                    flush_id = sel_flush_id;
                    case (sel_class)
                        SEL_HALT:  state_nx = HALT;
                        SEL_STALL: wpcir = 1'b0;
                        SEL_SEQ:   wpcir = imem_ready;
                        default: begin
                            if (imem_ready) begin
                                wpcir = 1'b1;
                            end else begin
                                state_nx        = PEND;
                                pend_valid_nx   = 1'b1;
                                pend_pc_nx      = sel_target;
                                pend_is_trap_nx = (sel_class == SEL_TRAP);
                            end
                        end
                    endcase
                end
                PEND: begin
                    npc = pend_pc;
                    // A pending trap target must survive any younger branch resolving in EX.
                    if (sel_class == SEL_TRAP || (sel_class == SEL_BR && !pend_is_trap)) begin
                        npc             = sel_target;
                        flush_if        = sel_flush_if;
                        flush_id        = sel_flush_id;
                        pend_pc_nx      = sel_target;
                        pend_is_trap_nx = (sel_class == SEL_TRAP);
                    end
                    if (imem_ready && pend_valid) begin
                        wpcir           = 1'b1;
                        state_nx        = RUN;
                        pend_valid_nx   = 1'b0;
                        pend_is_trap_nx = 1'b0;
                    end
                end
                HALT: begin
                    halted = 1'b1;
                    if (sel_class == SEL_TRAP) begin
                        npc      = sel_target;
                        flush_if = sel_flush_if;
                        flush_id = sel_flush_id;
                        if (imem_ready) begin
                            wpcir    = 1'b1;
                            state_nx = RUN;
                        end else begin
                            state_nx        = PEND;
                            pend_valid_nx   = 1'b1;
                            pend_pc_nx      = sel_target;
                            pend_is_trap_nx = 1'b1;
                        end
                    end else if (resume) begin
                        state_nx = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_pc_ctrl.sv
// Scenario bench for pl_pc_ctrl; expected words are {npc, wpcir, flush_if, flush_id, halted}.
module tb_pl_pc_ctrl;
    import pl_pkg::*;

    logic        clk = 1'b0;
    logic        clrn, imem_ready, stall_lu, jal_valid, br_taken, trap_req, halt_req, resume;
    logic [31:0] pc, jal_target, br_target, trap_vec;
    logic [31:0] npc;
    logic        wpcir, flush_if, flush_id, halted;
    logic [31:0] stall_cycles;

    logic [35:0] sb[$];
    logic [35:0] exp_v;
    logic [35:0] obs;
    int          checks = 0;
    int          passed = 0;

    assign obs = {npc, wpcir, flush_if, flush_id, halted};

    always #5 clk = ~clk;

    pl_pc_ctrl dut (
        .clk          (clk),
        .clrn         (clrn),
        .pc           (pc),
        .imem_ready   (imem_ready),
        .stall_lu     (stall_lu),
        .jal_valid    (jal_valid),
        .jal_target   (jal_target),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .trap_req     (trap_req),
        .trap_vec     (trap_vec),
        .halt_req     (halt_req),
        .resume       (resume),
        .npc          (npc),
        .wpcir        (wpcir),
        .flush_if     (flush_if),
        .flush_id     (flush_id),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    function automatic logic [35:0] pack(input logic [31:0] n, input logic w, input logic fi,
                                         input logic fd, input logic h);
        return {n, w, fi, fd, h};
    endfunction

    task automatic idle();
        stall_lu  = 1'b0;
        jal_valid = 1'b0;
        br_taken  = 1'b0;
        trap_req  = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clrn = 1'b0; pc = 32'h123; imem_ready = 1'b1; trap_req = 1'b1; trap_vec = 32'h100;
        sb.push_back(pack(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_out: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cycles); else passed++;
        trap_req = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clrn = 1'b1; pc = 32'(i * 4);
            sb.push_back(pack(32'((i + 1) * 4), 1'b1, 1'b0, 1'b0, 1'b0));
            #1 exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) $display("[TB] FAIL seq%0d: got %h want %h", i, obs, exp_v); else passed++;
        end
    endtask

    task automatic test_stall_jal();
        @(negedge clk);
        clrn = 1'b0;
        sb.push_back(pack(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL stall_rst: got %h want %h", obs, exp_v); else passed++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            clrn = 1'b1; pc = 32'h40; stall_lu = 1'b1; jal_valid = 1'b1; jal_target = 32'h80;
            sb.push_back(pack(32'h40, 1'b0, 1'b0, 1'b0, 1'b0));
            #1 exp_v = sb.pop_front(); checks++;
            if (obs !== exp_v) $display("[TB] FAIL stall%0d: got %h want %h", i, obs, exp_v); else passed++;
        end
        @(negedge clk);
        stall_lu = 1'b0;
        sb.push_back(pack(32'h80, 1'b1, 1'b1, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL jal_after_stall: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd2) $display("[TB] FAIL stall_cnt: got %0d want 2", stall_cycles); else passed++;
        idle();
    endtask

    task automatic test_priority();
        @(negedge clk);
        pc = 32'h60; trap_req = 1'b1; trap_vec = 32'h100; br_taken = 1'b1; br_target = 32'h200;
        sb.push_back(pack(32'h100, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL trap_over_br: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        pc = 32'h100; trap_req = 1'b0; stall_lu = 1'b1;
        sb.push_back(pack(32'h200, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL br_over_stall: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd2) $display("[TB] FAIL prio_cnt: got %0d want 2", stall_cycles); else passed++;
        idle();
    endtask

    task automatic test_pending();
        @(negedge clk);
        pc = 32'h70; imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h300;
        sb.push_back(pack(32'h300, 1'b0, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL br_pend: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        br_taken = 1'b0; trap_req = 1'b1; trap_vec = 32'h100;
        sb.push_back(pack(32'h100, 1'b0, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL trap_in_pend: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        trap_req = 1'b0; br_taken = 1'b1; br_target = 32'h400;
        sb.push_back(pack(32'h100, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs[35:3] !== exp_v[35:3]) $display("[TB] FAIL br_no_overwrite: got %h want %h", obs[35:3], exp_v[35:3]); else passed++;
        @(negedge clk);
        br_taken = 1'b0; imem_ready = 1'b1;
        sb.push_back(pack(32'h100, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pend_release: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd5) $display("[TB] FAIL pend_cnt: got %0d want 5", stall_cycles); else passed++;
        @(negedge clk);
        pc = 32'h100;
        sb.push_back(pack(32'h104, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pend_back_to_run: got %h want %h", obs, exp_v); else passed++;
    endtask

    task automatic test_halt();
        @(negedge clk);
        pc = 32'h50; halt_req = 1'b1;
        sb.push_back(pack(32'h50, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs[3:0] !== exp_v[3:0]) $display("[TB] FAIL halt_enter: got %b want %b", obs[3:0], exp_v[3:0]); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            halt_req = 1'b0;
            sb.push_back(pack(32'h50, 1'b0, 1'b0, 1'b0, 1'b1));
            #1 exp_v = sb.pop_front(); checks++;
            if (obs[3:0] !== exp_v[3:0]) $display("[TB] FAIL halt_hold%0d: got %b want %b", i, obs[3:0], exp_v[3:0]); else passed++;
            checks++;
            if (stall_cycles !== 32'd6) $display("[TB] FAIL halt_cnt%0d: got %0d want 6", i, stall_cycles); else passed++;
        end
        @(negedge clk);
        resume = 1'b1;
        sb.push_back(pack(32'h50, 1'b0, 1'b0, 1'b0, 1'b1));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs[3:0] !== exp_v[3:0]) $display("[TB] FAIL resume_cycle: got %b want %b", obs[3:0], exp_v[3:0]); else passed++;
        @(negedge clk);
        resume = 1'b0;
        sb.push_back(pack(32'h54, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL after_resume: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd6) $display("[TB] FAIL resume_cnt: got %0d want 6", stall_cycles); else passed++;
    endtask

    task automatic test_boundary();
        @(negedge clk);
        pc = 32'hFFFF_FFFC;
        sb.push_back(pack(32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pc_wrap: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        pc = 32'h200; jal_valid = 1'b1; jal_target = 32'h103;
        sb.push_back(pack(32'h100, 1'b1, 1'b1, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL jal_align: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        pc = 32'h100; jal_target = 32'h180; imem_ready = 1'b0;
        sb.push_back(pack(32'h180, 1'b0, 1'b1, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL jal_pend: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        jal_valid = 1'b0; trap_req = 1'b1; trap_vec = 32'h20; imem_ready = 1'b1;
        sb.push_back(pack(32'h20, 1'b1, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pend_trap_ready: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd7) $display("[TB] FAIL bnd_cnt: got %0d want 7", stall_cycles); else passed++;
        @(negedge clk);
        trap_req = 1'b0; pc = 32'h20;
        sb.push_back(pack(32'h24, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL trap_then_seq: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        pc = 32'h300; br_taken = 1'b1; br_target = 32'h500; imem_ready = 1'b0;
        sb.push_back(pack(32'h500, 1'b0, 1'b1, 1'b1, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pend_for_reset: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        br_taken = 1'b0; clrn = 1'b0; imem_ready = 1'b1;
        sb.push_back(pack(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_in_pend: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        clrn = 1'b1; pc = 32'h0;
        sb.push_back(pack(32'h4, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL pend_discarded: got %h want %h", obs, exp_v); else passed++;
        checks++;
        if (stall_cycles !== 32'd0) $display("[TB] FAIL reset_cnt2: got %0d want 0", stall_cycles); else passed++;
        @(negedge clk);
        pc = 32'h10; halt_req = 1'b1;
        sb.push_back(pack(32'h10, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs[3:0] !== exp_v[3:0]) $display("[TB] FAIL halt2_enter: got %b want %b", obs[3:0], exp_v[3:0]); else passed++;
        @(negedge clk);
        halt_req = 1'b0;
        sb.push_back(pack(32'h10, 1'b0, 1'b0, 1'b0, 1'b1));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs[3:0] !== exp_v[3:0]) $display("[TB] FAIL halt2_hold: got %b want %b", obs[3:0], exp_v[3:0]); else passed++;
        @(negedge clk);
        clrn = 1'b0;
        sb.push_back(pack(32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_in_halt: got %h want %h", obs, exp_v); else passed++;
        @(negedge clk);
        clrn = 1'b1; pc = 32'h10;
        sb.push_back(pack(32'h14, 1'b1, 1'b0, 1'b0, 1'b0));
        #1 exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) $display("[TB] FAIL halt_discarded: got %h want %h", obs, exp_v); else passed++;
    endtask

    initial begin
        clrn       = 1'b0;
        pc         = 32'h0;
        imem_ready = 1'b1;
        jal_target = 32'h0;
        br_target  = 32'h0;
        trap_vec   = 32'h0;
        idle();
        test_reset();
        test_sequential();
        test_stall_jal();
        test_priority();
        test_pending();
        test_halt();
        test_boundary();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
